// File: rtl/debam_divider_seq.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and
// remainder, one quotient bit per cycle, valid/ready on both sides.
// Optional build macro DEBAM_DIVIDER_ROUND_EN: round the quotient to nearest (saturating)
// on completion; the remainder stays truncated.
module debam_divider_seq #(
    parameter int unsigned N = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] DIVIDEND,
    input  logic [N-1:0]   DIVISOR,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   QUOTIENT,
    output logic [N-1:0]   REMAINDER,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    d_q, d_d;
    logic [N:0]      r_q, r_d;
    logic [N-1:0]    q_q, q_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    dividend_hi;
    logic [N:0]      r_shift;
    logic [N:0]      r_diff;
    logic            fits;
    logic [N:0]      r_next;
    logic [N-1:0]    q_next;
    logic [N-1:0]    q_final;
    logic            unused_r_msb;

    assign dividend_hi = DIVIDEND[2*N-1:N];

    // One restoring step: shift {R,Q} left, trial-subtract D, keep the difference if it fits.
    always_comb begin
        r_shift = {r_q[N-1:0], q_q[N-1]};
        fits    = (r_shift >= {1'b0, d_q});
        r_diff  = r_shift - {1'b0, d_q};
        r_next  = fits ? r_diff : r_shift;
        q_next  = {q_q[N-2:0], fits};
    end

    // R < D after every step, so its top bit is always clear once the step completes.
    assign unused_r_msb = r_next[N];

`ifdef DEBAM_DIVIDER_ROUND_EN
    // Round to nearest: bump the quotient when 2R >= D, saturating at all-ones.
    always_comb begin
        q_final = q_next;
        if (({r_next, 1'b0} >= {2'b00, d_q}) && !(&q_next)) begin
            q_final = q_next + {{(N-1){1'b0}}, 1'b1};
        end
    end
`else
    // Truncated quotient.
    always_comb begin
        q_final = q_next;
    end
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    d_d = DIVISOR;
                    if (DIVISOR == '0) begin
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (dividend_hi >= DIVISOR) begin
                        // Quotient would need more than N bits.
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                        r_d     = {1'b0, dividend_hi};
                        q_d     = DIVIDEND[N-1:0];
                        cnt_d   = '0;
                    end
                end
            end
            StCalc: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    quot_d  = q_final;
                    rem_d   = r_next[N-1:0];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign QUOTIENT    = quot_q;
    assign REMAINDER   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_debam_divider_seq.sv
// Directed self-checking bench for debam_divider_seq (N=8).
module tb_debam_divider_seq;

    localparam int unsigned N = 8;
`ifdef DEBAM_DIVIDER_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] DIVIDEND;
    logic [N-1:0]   DIVISOR;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   QUOTIENT;
    logic [N-1:0]   REMAINDER;
    logic           div_by_zero;
    logic           overflow;

    int checks   = 0;
    int failures = 0;

    debam_divider_seq #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for out_valid, sampling on falling edges; returns cycles since the input handshake.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (out_valid || cyc >= 40) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                          input logic [7:0] eq_t, input logic [7:0] eq_r, input logic [7:0] er,
                          input logic ez, input logic eo, input int lat);
        int cyc;
        logic [7:0] eq;
        eq = RoundEn ? eq_r : eq_t;
        @(negedge clock);
        check_eq({tag, ".in_ready"}, in_ready, 1);
        out_ready = 1'b1;
        DIVIDEND  = dd;
        DIVISOR   = dv;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        // Operands must be ignored after the handshake.
        DIVIDEND = ~dd;
        DIVISOR  = ~dv;
        wait_valid(cyc);
        check_eq({tag, ".latency"}, cyc, lat);
        check_eq({tag, ".quot"}, QUOTIENT, eq);
        check_eq({tag, ".rem"}, REMAINDER, er);
        check_eq({tag, ".dbz"}, div_by_zero, ez);
        check_eq({tag, ".ovf"}, overflow, eo);
        check_eq({tag, ".in_ready_done"}, in_ready, 0);
        @(negedge clock);
        check_eq({tag, ".post_valid"}, out_valid, 0);
        check_eq({tag, ".post_quot"}, QUOTIENT, eq);
    endtask

    initial begin
        int  cyc;
        logic seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        DIVIDEND  = '0;
        DIVISOR   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_eq("rst.in_ready", in_ready, 1);
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.quot", QUOTIENT, 0);
        check_eq("rst.rem", REMAINDER, 0);
        check_eq("rst.flags", {div_by_zero, overflow}, 0);

        //     tag          dividend   divisor  q_trunc  q_round  rem    dbz  ovf  latency
        run_op("d1000_7",   16'd1000,  8'd7,    8'd142,  8'd143,  8'd6,   0,   0,   N + 1);
        run_op("dbz",       16'h1234,  8'd0,    8'hFF,   8'hFF,   8'd0,   1,   0,   1);
        run_op("ovf",       16'h0800,  8'd8,    8'hFF,   8'hFF,   8'd0,   0,   1,   1);
        run_op("max_q",     16'h07F8,  8'd8,    8'd255,  8'd255,  8'd0,   0,   0,   N + 1);
        run_op("d_ff",      16'hFEFF,  8'hFF,   8'd255,  8'd255,  8'd254, 0,   0,   N + 1);
        run_op("d_one",     16'h00AB,  8'd1,    8'd171,  8'd171,  8'd0,   0,   0,   N + 1);
        run_op("d1001_10",  16'd1001,  8'd10,   8'd100,  8'd100,  8'd1,   0,   0,   N + 1);
        run_op("d59_10",    16'd59,    8'd10,   8'd5,    8'd6,    8'd9,   0,   0,   N + 1);
        run_op("ovf_one",   16'h0100,  8'd1,    8'hFF,   8'hFF,   8'd0,   0,   1,   1);

        // Backpressure: hold the result for 5 cycles while a new request is offered.
        @(negedge clock);
        out_ready = 1'b0;
        DIVIDEND  = 16'd1000;
        DIVISOR   = 8'd7;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc);
        check_eq("bp.latency", cyc, N + 1);
        for (int i = 0; i < 5; i++) begin
            DIVIDEND = 16'h0100;
            DIVISOR  = 8'd0;
            in_valid = 1'b1;
            @(negedge clock);
            check_eq("bp.hold_valid", out_valid, 1);
            check_eq("bp.hold_in_ready", in_ready, 0);
            check_eq("bp.hold_quot", QUOTIENT, RoundEn ? 143 : 142);
            check_eq("bp.hold_rem", REMAINDER, 6);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check_eq("bp.released_valid", out_valid, 0);
        check_eq("bp.released_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clock);
        check_eq("bp.not_accepted", in_ready, 1);
        check_eq("bp.no_dbz", div_by_zero, 0);

        // Reset in the middle of a calculation discards it.
        DIVIDEND = 16'd1000;
        DIVISOR  = 8'd7;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rst_mid.in_ready", in_ready, 1);
        check_eq("rst_mid.out_valid", out_valid, 0);
        check_eq("rst_mid.quot", QUOTIENT, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst_mid.no_result", seen, 0);
        run_op("d255_15",   16'd255,   8'd15,   8'd17,   8'd17,   8'd0,   0,   0,   N + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
